// File: rtl/wb_pkg.sv
// wb_pkg: source indices, state encoding and select-width helper for the write-back stage.
package wb_pkg;
  localparam int WB_SRC_PC  = 0;
  localparam int WB_SRC_DM  = 1;
  localparam int WB_SRC_ALU = 2;
  typedef enum logic {IDLE = 1'b0, WAIT_SRC = 1'b1} wb_state_e;
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/wb_select_stage_if.sv
// wb_select_stage_if: transaction, source, register-bank write and error signals of the write-back stage.
interface wb_select_stage_if #(
  parameter int DATA_W = 32,
  parameter int NSRC   = 4,
  parameter int ADDR_W = 4
) ();
  localparam int SEL_W = wb_pkg::sel_w(NSRC);
  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       in_sel;
  logic [ADDR_W-1:0]      in_rd;
  logic [NSRC*DATA_W-1:0] in_src_data;
  logic [NSRC-1:0]        in_src_valid;
  logic                   out_we;
  logic [ADDR_W-1:0]      out_addr;
  logic [DATA_W-1:0]      out_data;
  logic                   err_sel;
  logic                   err_timeout;
  logic                   err_clr;
  modport slave (
    input  in_valid, in_sel, in_rd, in_src_data, in_src_valid, err_clr,
    output in_ready, out_we, out_addr, out_data, err_sel, err_timeout
  );
  modport master (
    output in_valid, in_sel, in_rd, in_src_data, in_src_valid, err_clr,
    input  in_ready, out_we, out_addr, out_data, err_sel, err_timeout
  );
endinterface

// File: rtl/wb_src_mux.sv
// wb_src_mux: NSRC-way indexed slice of the flattened source bus; out-of-range selects yield zero/invalid.
module wb_src_mux #(
  parameter int DATA_W = 32,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]       sel_i,
  input  logic [NSRC*DATA_W-1:0] src_data_i,
  input  logic [NSRC-1:0]        src_valid_i,
  output logic [DATA_W-1:0]      data_o,
  output logic                   valid_o
);
  always_comb begin
    data_o  = '0;
    valid_o = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o  = src_data_i[k*DATA_W +: DATA_W];
        valid_o = src_valid_i[k];
      end
    end
  end
endmodule

// File: rtl/wb_select_stage.sv
// wb_select_stage: registered write-back source selector with bounded wait for late sources.
// Optional WB_SELECT_STATS_EN adds wb_count / wb_stall_cycles counters.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NSRC     = 4,
  parameter int ADDR_W   = 4,
  parameter int TIMEOUT  = 15,
  parameter int ZERO_REG = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef WB_SELECT_STATS_EN
  output logic [31:0] wb_count,
  output logic [31:0] wb_stall_cycles,
`endif
  wb_select_stage_if.slave bus
);
  localparam int SEL_W = sel_w(NSRC);
  wb_state_e         state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d, mux_sel;
  logic [ADDR_W-1:0] rd_q, rd_d, addr_q, addr_d, cap_rd;
  logic [DATA_W-1:0] data_q, data_d, src_data;
  logic              we_q, we_d, err_sel_q, err_to_q;
  logic              src_vld, cap, set_sel, set_to;
  assign mux_sel = (state_q == IDLE) ? bus.in_sel : sel_q;
  wb_src_mux #(.DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W)) u_mux (
    .sel_i       (mux_sel),
    .src_data_i  (bus.in_src_data),
    .src_valid_i (bus.in_src_valid),
    .data_o      (src_data),
    .valid_o     (src_vld)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    cap     = 1'b0;
    cap_rd  = rd_q;
    set_sel = 1'b0;
    set_to  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.in_valid) begin
        if (int'(bus.in_sel) >= NSRC) set_sel = 1'b1;
        else if (src_vld) begin
          cap    = 1'b1;
          cap_rd = bus.in_rd;
        end else begin
          sel_d   = bus.in_sel;
          rd_d    = bus.in_rd;
          cnt_d   = '0;
          state_d = WAIT_SRC;
        end
      end
    end else if (src_vld) begin
      cap     = 1'b1;
      state_d = IDLE;
    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
      set_to  = 1'b1;
      state_d = IDLE;
    end else cnt_d = cnt_q + 8'd1;
    // r0 writes complete the transaction but never reach the bank
    if (cap && !(ZERO_REG != 0 && cap_rd == '0)) begin
      we_d   = 1'b1;
      addr_d = cap_rd;
      data_d = src_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      err_sel_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_sel_q <= set_sel | (err_sel_q & ~bus.err_clr);
      err_to_q  <= set_to | (err_to_q & ~bus.err_clr);
    end
  end
`ifdef WB_SELECT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_count        <= '0;
      wb_stall_cycles <= '0;
    end else begin
      wb_count        <= wb_count + 32'(we_q);
      wb_stall_cycles <= wb_stall_cycles + 32'(state_q == WAIT_SRC);
    end
  end
`endif
  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_we      = we_q;
  assign bus.out_addr    = addr_q;
  assign bus.out_data    = data_q;
  assign bus.err_sel     = err_sel_q;
  assign bus.err_timeout = err_to_q;
endmodule

// File: tb/tb_wb_select_stage.sv
// tb_wb_select_stage: scoreboard bench; stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_wb_select_stage;
  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  wr_t  exp_q[$];
  always #5 clk = ~clk;
  wb_select_stage_if #(.DATA_W(32), .NSRC(3), .ADDR_W(4)) bus ();
  wb_select_stage #(.DATA_W(32), .NSRC(3), .ADDR_W(4), .TIMEOUT(15), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic offer(input logic [1:0] sel, input logic [3:0] rd, input logic [2:0] vld);
    bus.in_valid     = 1'b1;
    bus.in_sel       = sel;
    bus.in_rd        = rd;
    bus.in_src_valid = vld;
  endtask
  task automatic idle_in();
    bus.in_valid     = 1'b0;
    bus.in_src_valid = 3'b000;
  endtask
  task automatic set_src(input int i, input logic [31:0] d);
    bus.in_src_data[i*32 +: 32] = d;
  endtask
  always @(negedge clk) begin
    if (bus.out_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", bus.out_addr, bus.out_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.out_addr !== e.addr || bus.out_data !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   bus.out_addr, bus.out_data, e.addr, e.data);
        end
      end
    end
  end
  initial begin
    rst_n       = 1'b0;
    bus.err_clr = 1'b0;
    bus.in_sel  = '0;
    bus.in_rd   = '0;
    bus.in_src_data = '0;
    idle_in();
    step();
    step();
    chk("rst_we", 32'(bus.out_we), 0);
    chk("rst_addr", 32'(bus.out_addr), 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_err_sel", 32'(bus.err_sel), 0);
    chk("rst_err_to", 32'(bus.err_timeout), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;
    // reset while waiting on DM drops the transaction
    offer(2'd1, 4'd5, 3'b000);
    step();
    idle_in();
    chk("wait_ready", 32'(bus.in_ready), 0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_ready", 32'(bus.in_ready), 1);
    chk("midrst_we", 32'(bus.out_we), 0);
    chk("midrst_addr", 32'(bus.out_addr), 0);
    chk("midrst_data", bus.out_data, 0);
    step();
    // immediate ALU write
    set_src(0, 32'h0000_0040);
    set_src(2, 32'hDEAD_BEEF);
    offer(2'd2, 4'd3, 3'b100);
    exp_q.push_back('{4'd3, 32'hDEAD_BEEF});
    step();
    idle_in();
    chk("alu_we", 32'(bus.out_we), 1);
    step();
    chk("alu_we_drop", 32'(bus.out_we), 0);
    // back-to-back PC / ALU / PC
    set_src(0, 32'h0000_0100);
    offer(2'd0, 4'd1, 3'b111);
    exp_q.push_back('{4'd1, 32'h0000_0100});
    step();
    set_src(2, 32'hA5A5_A5A5);
    offer(2'd2, 4'd2, 3'b111);
    exp_q.push_back('{4'd2, 32'hA5A5_A5A5});
    step();
    set_src(0, 32'h0000_0104);
    offer(2'd0, 4'd4, 3'b111);
    exp_q.push_back('{4'd4, 32'h0000_0104});
    step();
    idle_in();
    step();
    step();
    chk("b2b_drained", 32'(exp_q.size()), 0);
    // late DM: four stall cycles, then one write
    offer(2'd1, 4'd7, 3'b000);
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      chk("late_ready", 32'(bus.in_ready), 0);
      step();
    end
    chk("late_ready", 32'(bus.in_ready), 0);
    set_src(1, 32'h1234_5678);
    bus.in_src_valid = 3'b010;
    exp_q.push_back('{4'd7, 32'h1234_5678});
    step();
    bus.in_src_valid = 3'b000;
    chk("late_ready_back", 32'(bus.in_ready), 1);
    step();
    // timeout after 15 wait cycles
    offer(2'd1, 4'd9, 3'b000);
    step();
    idle_in();
    for (int i = 0; i < 14; i++) step();
    chk("to_not_yet", 32'(bus.err_timeout), 0);
    chk("to_still_wait", 32'(bus.in_ready), 0);
    step();
    chk("to_flag", 32'(bus.err_timeout), 1);
    chk("to_ready", 32'(bus.in_ready), 1);
    // illegal select with NSRC=3
    offer(2'd3, 4'd2, 3'b111);
    step();
    idle_in();
    chk("sel_flag", 32'(bus.err_sel), 1);
    chk("sel_ready", 32'(bus.in_ready), 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("clr_sel", 32'(bus.err_sel), 0);
    chk("clr_to", 32'(bus.err_timeout), 0);
    // set beats clear in the same cycle
    offer(2'd3, 4'd2, 3'b000);
    bus.err_clr = 1'b1;
    step();
    idle_in();
    bus.err_clr = 1'b0;
    chk("set_wins", 32'(bus.err_sel), 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("clr_again", 32'(bus.err_sel), 0);
    // valid on the final wait cycle wins over timeout
    offer(2'd1, 4'd6, 3'b000);
    step();
    idle_in();
    for (int i = 0; i < 14; i++) step();
    set_src(1, 32'hCAFE_F00D);
    bus.in_src_valid = 3'b010;
    exp_q.push_back('{4'd6, 32'hCAFE_F00D});
    step();
    bus.in_src_valid = 3'b000;
    chk("edge_no_to", 32'(bus.err_timeout), 0);
    chk("edge_we", 32'(bus.out_we), 1);
    step();
    // r0 writes are suppressed, outputs hold the last write
    set_src(2, 32'h0000_0055);
    offer(2'd2, 4'd0, 3'b100);
    step();
    idle_in();
    chk("zero_we", 32'(bus.out_we), 0);
    chk("zero_addr_hold", 32'(bus.out_addr), 6);
    chk("zero_data_hold", bus.out_data, 32'hCAFE_F00D);
    offer(2'd1, 4'd0, 3'b000);
    step();
    idle_in();
    step();
    bus.in_src_valid = 3'b010;
    step();
    bus.in_src_valid = 3'b000;
    chk("zero_late_we", 32'(bus.out_we), 0);
    chk("zero_late_ready", 32'(bus.in_ready), 1);
    step();
    step();
    chk("final_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
